// File: rtl/ddr_rd_arbiter.sv
// rtl/ddr_rd_arbiter.sv - round-robin arbiter sharing one DDR read port among NUM_REQ requesters
// One burst outstanding at a time; returned beats are steered to the requester that owns the burst.
module ddr_rd_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int MAX_BURST = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_rd,
    input  logic [29*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_burstcnt,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [NUM_REQ-1:0]   req_valid,
    output logic [63:0]          req_readdata,
    output logic [28:0]          ddram_addr,
    output logic [7:0]           ddram_burstcnt,
    output logic                 ddram_rd,
    input  logic                 ddram_busy,
    input  logic                 ddram_valid_in,
    input  logic [63:0]          ddram_readdata_in,
    output logic [ID_W-1:0]      active_id,
    output logic                 idle
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_last_grant;
    logic [7:0]        r_beats;

    logic              w_found;
    logic [ID_W-1:0]   w_grant;
    logic [ID_W-1:0]   w_sel;
    int                w_idx;
    logic [28:0]       w_addr;
    logic [7:0]        w_burst_raw;
    logic [7:0]        w_burst;

    // Search upward from the requester after the last winner, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = 0;
        w_sel   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(r_last_grant) + k) % NUM_REQ;
            w_sel = ID_W'(w_idx);
            if (!w_found && req_rd[w_sel]) begin
                w_found = 1'b1;
                w_grant = w_sel;
            end
        end
    end

    always_comb begin
        w_addr      = '0;
        w_burst_raw = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == ID_W'(i)) begin
                w_addr      = req_addr[29*i +: 29];
                w_burst_raw = req_burstcnt[8*i +: 8];
            end
        end
        if (w_burst_raw == 8'd0)
            w_burst = 8'd1;
        else if (w_burst_raw > 8'(MAX_BURST))
            w_burst = 8'(MAX_BURST);
        else
            w_burst = w_burst_raw;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_last_grant   <= ID_W'(NUM_REQ - 1);
            r_beats        <= '0;
            ddram_rd       <= 1'b0;
            ddram_addr     <= '0;
            ddram_burstcnt <= '0;
            req_ack        <= '0;
            req_valid      <= '0;
            req_readdata   <= '0;
            active_id      <= '0;
            idle           <= 1'b1;
        end else begin
            req_ack   <= '0;
            req_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        active_id      <= w_grant;
                        ddram_addr     <= w_addr;
                        ddram_burstcnt <= w_burst;
                        r_beats        <= w_burst;
                        ddram_rd       <= 1'b1;
                        idle           <= 1'b0;
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!ddram_busy) begin
                        ddram_rd     <= 1'b0;
                        req_ack      <= NUM_REQ'(1) << active_id;
                        r_last_grant <= active_id;
                        r_state      <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (ddram_valid_in) begin
                        req_readdata <= ddram_readdata_in;
                        req_valid    <= NUM_REQ'(1) << active_id;
                        r_beats      <= r_beats - 8'd1;
                        if (r_beats == 8'd1) begin
                            idle    <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    idle    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ddr_rd_arbiter.md
Name: ddr_rd_arbiter

Overview:
- Shares the single PVR-side DDR3 read port between NUM_REQ requesters, e.g. the texture cache line filler, ISP/TSP parameter fetch, region-array walker and framebuffer reader.
- Round-robin arbitration with one outstanding burst at a time.
- Issues the burst command, tracks returned beats and routes each beat's valid pulse to the owning requester.
- Sits between the requester caches and the DDR controller.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester index (clog2 of NUM_REQ)
MAX_BURST, 8, largest burst forwarded; larger requests are clamped to this

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req_rd  in  NUM_REQ  per-requester read request level; held until matching req_ack
req_addr  in  29*NUM_REQ  flattened 64-bit-word addresses; requester i at [29*i+28:29*i]
req_burstcnt  in  8*NUM_REQ  flattened burst lengths in words
req_ack  out  NUM_REQ  one-cycle pulse: command of requester i accepted by DDR
req_valid  out  NUM_REQ  one-cycle pulse per returned beat, to owner only
req_readdata  out  64  returned beat, shared by all requesters; qualified by req_valid
ddram_addr  out  29  command address to DDR controller
ddram_burstcnt  out  8  command burst length
ddram_rd  out  1  read command, held until accepted
ddram_busy  in  1  controller not ready; command accepted on a cycle with ddram_rd=1 and ddram_busy=0
ddram_valid_in  in  1  returned beat valid
ddram_readdata_in  in  64  returned beat data
active_id  out  ID_W  index of current owner
idle  out  1  high in IDLE state

Behaviour:
Reset values (sync, active-high):
- state=IDLE, ddram_rd=0, ddram_addr=0, ddram_burstcnt=0.
- req_ack=0, req_valid=0, req_readdata=0, active_id=0, idle=1.
- last_grant=NUM_REQ-1, so requester 0 has top priority after reset.

IDLE:
- If any req_rd bit is set, pick the first set bit searching upward from last_grant+1, with wrap.
- Register the winner's index into active_id.
- Register its address into ddram_addr and its burst into ddram_burstcnt and the beat counter.
- Burst rules: 0 becomes 1; values above MAX_BURST become MAX_BURST.
- Assert ddram_rd and go to ISSUE.
- First ddram_rd is high the cycle after req_rd is sampled, i.e. 1-cycle arbitration latency.

ISSUE:
- ddram_rd, ddram_addr and ddram_burstcnt stay stable while ddram_busy=1.
- On an edge with ddram_busy=0: clear ddram_rd, pulse req_ack[active_id] for one cycle, set last_grant=active_id, go to DATA.

DATA:
- Each ddram_valid_in: req_readdata<=ddram_readdata_in and req_valid[active_id]<=1 for one cycle. Latency is 1 cycle.
- Decrement the beat counter on each beat.
- On the final beat, go to IDLE. A new arbitration can occur on the very next cycle, so there is no dead cycle beyond IDLE.

Other rules:
- ddram_valid_in outside DATA (IDLE/ISSUE, e.g. stray beats after reset) is ignored; no req_valid is generated.
- A requester deasserting req_rd after winning arbitration does not cancel the command; the burst completes and its beats are still delivered.
- Requests arriving during ISSUE/DATA wait; req_rd is only sampled in IDLE.
- Reset mid-burst: return to IDLE immediately; no further req_valid pulses; remaining beats from the controller are discarded.
- req_valid is one-hot or zero; req_ack is one-hot or zero; they never coincide for the same beat cycle.

Test Plan:
- Single request: req_rd[0]=1, addr 0x0001_0000, burst 8, ddram_busy=0 → ddram_rd high 1 cycle with addr 0x0001_0000/burst 8; req_ack[0] pulse; 8 data beats → 8 req_valid[0] pulses, data 1 cycle late; idle=1 after last beat.
- Round-robin: req_rd=4'b1111 held, ack each and drop → grant order 0,1,2,3; then re-raise 0 and 2 → grant 0 then 2.
- Backpressure: ddram_busy=1 for 5 cycles after ddram_rd → addr/burst stable for 6 cycles, req_ack only on the accept cycle.
- Clamp: burst 0 → ddram_burstcnt=1, one beat delivered; burst 20 → ddram_burstcnt=8, return to IDLE after 8 beats.
- Reset mid-burst: reset after 3 of 8 beats, then 5 more ddram_valid_in → no req_valid; next request on requester 1 is served normally with requester 0 first-priority semantics.
- Stray beat: ddram_valid_in while idle → no req_valid; the next burst delivers exactly burstcnt beats.
